// File: rtl/flash_sample_fetcher.sv
// rtl/flash_sample_fetcher.sv - Avalon-MM flash reader that splits 32-bit words into 16-bit PCM samples
// One word fetch serves two sample ticks; the half order is latched together with the word.
module flash_sample_fetcher #(
  parameter logic [22:0] START_ADDR = 23'h000000,
  parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
  input  logic        CLK_50M,
  input  logic        reset_n,
  input  logic        sample_tick,
  input  logic        play,
  input  logic        direction,
  input  logic        restart,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  input  logic        flash_mem_waitrequest,
  input  logic        flash_mem_readdatavalid,
  input  logic [31:0] flash_mem_readdata,
  output logic [15:0] audio_data,
  output logic        sample_valid,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_e;

  state_e      state_q;
  logic        half_q;
  logic [31:0] buf_q;
  logic        dir_cap_q;
  logic        pend_q;
  logic        read_q;
  logic [22:0] addr_q;
  logic [15:0] audio_q;
  logic        valid_q;
  logic        overrun_q;

  logic [22:0] adv_addr_d;
  logic [22:0] rewind_addr_d;
  logic [15:0] second_half_d;
  logic [15:0] first_half_d;
  logic        tick_play;

  assign tick_play = sample_tick & play;

  // Advance and rewind both follow the live direction input; only the half order is latched.
  always_comb begin
    adv_addr_d    = addr_q;
    rewind_addr_d = direction ? END_ADDR : START_ADDR;
    if (direction) begin
      adv_addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - 23'd1;
    end else begin
      adv_addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + 23'd1;
    end
    second_half_d = dir_cap_q ? buf_q[15:0] : buf_q[31:16];
    first_half_d  = direction ? flash_mem_readdata[31:16] : flash_mem_readdata[15:0];
  end

  always_ff @(posedge CLK_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      half_q    <= 1'b0;
      buf_q     <= 32'h0;
      dir_cap_q <= 1'b0;
      pend_q    <= 1'b0;
      read_q    <= 1'b0;
      addr_q    <= START_ADDR;
      audio_q   <= 16'h0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (restart) begin
            addr_q <= rewind_addr_d;
            half_q <= 1'b0;
          end else if (tick_play) begin
            if (!half_q) begin
              state_q <= REQ;
              read_q  <= 1'b1;
            end else begin
              audio_q <= second_half_d;
              valid_q <= 1'b1;
              half_q  <= 1'b0;
              addr_q  <= adv_addr_d;
            end
          end
        end
        REQ: begin
          if (tick_play) overrun_q <= 1'b1;
          if (restart)   pend_q    <= 1'b1;
          if (!flash_mem_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (tick_play) overrun_q <= 1'b1;
          if (flash_mem_readdatavalid) begin
            state_q <= IDLE;
            // A restart seen at any point during the transaction discards the word.
            if (pend_q || restart) begin
              pend_q <= 1'b0;
              addr_q <= rewind_addr_d;
              half_q <= 1'b0;
            end else begin
              buf_q     <= flash_mem_readdata;
              dir_cap_q <= direction;
              audio_q   <= first_half_d;
              valid_q   <= 1'b1;
              half_q    <= 1'b1;
            end
          end else if (restart) begin
            pend_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign flash_mem_read    = read_q;
  assign flash_mem_address = addr_q;
  assign audio_data        = audio_q;
  assign sample_valid      = valid_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// tb/tb_flash_sample_fetcher.sv - directed self-checking bench for flash_sample_fetcher
module tb_flash_sample_fetcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic        play;
  logic        direction;
  logic        restart;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic        flash_mem_waitrequest;
  logic        flash_mem_readdatavalid;
  logic [31:0] flash_mem_readdata;
  logic [15:0] audio_data;
  logic        sample_valid;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  logic        rd_s;
  logic [22:0] ad_s;
  logic [15:0] au_s;
  logic        vl_s;

  always #5 clk = ~clk;

  flash_sample_fetcher #(
    .START_ADDR(23'h000000),
    .END_ADDR  (23'h07FFFF)
  ) dut (
    .CLK_50M                (clk),
    .reset_n                (reset_n),
    .sample_tick            (sample_tick),
    .play                   (play),
    .direction              (direction),
    .restart                (restart),
    .flash_mem_read         (flash_mem_read),
    .flash_mem_address      (flash_mem_address),
    .flash_mem_waitrequest  (flash_mem_waitrequest),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .flash_mem_readdata     (flash_mem_readdata),
    .audio_data             (audio_data),
    .sample_valid           (sample_valid),
    .overrun                (overrun)
  );

  // Tick, observe the request, then return the word one cycle after acceptance.
  task automatic fetch_word(input logic [31:0] word, output logic rd_o, output logic [22:0] addr_o,
                            output logic [15:0] aud_o, output logic vld_o);
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    rd_o   = flash_mem_read;
    addr_o = flash_mem_address;
    @(negedge clk);
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = word;
    @(negedge clk);
    flash_mem_readdatavalid = 1'b0;
    aud_o = audio_data;
    vld_o = sample_valid;
  endtask

  task automatic tick_once(output logic [15:0] aud_o, output logic vld_o, output logic [22:0] addr_o);
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    aud_o  = audio_data;
    vld_o  = sample_valid;
    addr_o = flash_mem_address;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; sample_tick = 1'b0; play = 1'b1; direction = 1'b0; restart = 1'b0;
    flash_mem_waitrequest = 1'b0; flash_mem_readdatavalid = 1'b0; flash_mem_readdata = 32'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (flash_mem_read !== 1'b0 || flash_mem_address !== 23'h0 || audio_data !== 16'h0 ||
        sample_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rd=%b addr=%h aud=%h vld=%b ovr=%b exp rd=0 addr=0 aud=0 vld=0 ovr=0",
               flash_mem_read, flash_mem_address, audio_data, sample_valid, overrun);
    end
  endtask

  task automatic test_forward;
    fetch_word(32'h0002_0001, rd_s, ad_s, au_s, vl_s);
    checks++;
    if (rd_s !== 1'b1 || ad_s !== 23'h0) begin
      failures++; $display("FAIL fwd_read got rd=%b addr=%h exp rd=1 addr=0", rd_s, ad_s);
    end
    checks++;
    if (au_s !== 16'h0001 || vl_s !== 1'b1) begin
      failures++; $display("FAIL fwd_first got aud=%h vld=%b exp aud=0001 vld=1", au_s, vl_s);
    end
    tick_once(au_s, vl_s, ad_s);
    checks++;
    if (au_s !== 16'h0002 || vl_s !== 1'b1 || ad_s !== 23'h1) begin
      failures++; $display("FAIL fwd_second got aud=%h vld=%b addr=%h exp aud=0002 vld=1 addr=1", au_s, vl_s, ad_s);
    end
  endtask

  task automatic test_backward;
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    checks++;
    if (flash_mem_address !== 23'h0 || sample_valid !== 1'b0 || audio_data !== 16'h0002) begin
      failures++;
      $display("FAIL idle_restart got addr=%h vld=%b aud=%h exp addr=0 vld=0 aud=0002",
               flash_mem_address, sample_valid, audio_data);
    end
    direction = 1'b1;
    fetch_word(32'hBBBB_AAAA, rd_s, ad_s, au_s, vl_s);
    checks++;
    if (rd_s !== 1'b1 || ad_s !== 23'h0 || au_s !== 16'hBBBB || vl_s !== 1'b1) begin
      failures++;
      $display("FAIL bwd_first got rd=%b addr=%h aud=%h vld=%b exp rd=1 addr=0 aud=BBBB vld=1", rd_s, ad_s, au_s, vl_s);
    end
    tick_once(au_s, vl_s, ad_s);
    checks++;
    if (au_s !== 16'hAAAA || vl_s !== 1'b1 || ad_s !== 23'h7FFFF) begin
      failures++; $display("FAIL bwd_wrap got aud=%h vld=%b addr=%h exp aud=AAAA vld=1 addr=7ffff", au_s, vl_s, ad_s);
    end
  endtask

  task automatic test_end_wrap;
    direction = 1'b0;
    fetch_word(32'h1111_2222, rd_s, ad_s, au_s, vl_s);
    checks++;
    if (ad_s !== 23'h7FFFF || au_s !== 16'h2222) begin
      failures++; $display("FAIL end_fetch got addr=%h aud=%h exp addr=7ffff aud=2222", ad_s, au_s);
    end
    tick_once(au_s, vl_s, ad_s);
    checks++;
    if (au_s !== 16'h1111 || ad_s !== 23'h0) begin
      failures++; $display("FAIL end_wrap got aud=%h addr=%h exp aud=1111 addr=0", au_s, ad_s);
    end
    fetch_word(32'h0004_0003, rd_s, ad_s, au_s, vl_s);
    checks++;
    if (rd_s !== 1'b1 || ad_s !== 23'h0 || au_s !== 16'h0003) begin
      failures++; $display("FAIL wrap_refetch got rd=%b addr=%h aud=%h exp rd=1 addr=0 aud=0003", rd_s, ad_s, au_s);
    end
    tick_once(au_s, vl_s, ad_s);
    checks++;
    if (au_s !== 16'h0004 || ad_s !== 23'h1) begin
      failures++; $display("FAIL wrap_second got aud=%h addr=%h exp aud=0004 addr=1", au_s, ad_s);
    end
  endtask

  task automatic test_stall;
    int  ovr_cnt;
    int  vld_cnt;
    bit  stable;
    flash_mem_waitrequest = 1'b1;
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    ovr_cnt = 0; vld_cnt = 0; stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (flash_mem_read !== 1'b1 || flash_mem_address !== 23'h1) stable = 1'b0;
      if (overrun === 1'b1) ovr_cnt++;
      if (sample_valid === 1'b1) vld_cnt++;
      sample_tick = (i == 1);
      @(negedge clk);
    end
    checks++;
    if (!stable || flash_mem_read !== 1'b1) begin
      failures++; $display("FAIL stall_hold got stable=%0d rd=%b exp stable=1 rd=1", stable, flash_mem_read);
    end
    checks++;
    if (ovr_cnt != 1 || vld_cnt != 0) begin
      failures++; $display("FAIL stall_overrun got ovr=%0d vld=%0d exp ovr=1 vld=0", ovr_cnt, vld_cnt);
    end
    flash_mem_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (flash_mem_read !== 1'b0) begin
      failures++; $display("FAIL stall_accept got rd=%b exp rd=0", flash_mem_read);
    end
    flash_mem_readdatavalid = 1'b1; flash_mem_readdata = 32'h5678_1234;
    @(negedge clk);
    flash_mem_readdatavalid = 1'b0;
    checks++;
    if (audio_data !== 16'h1234 || sample_valid !== 1'b1) begin
      failures++; $display("FAIL stall_data got aud=%h vld=%b exp aud=1234 vld=1", audio_data, sample_valid);
    end
    tick_once(au_s, vl_s, ad_s);
    checks++;
    if (au_s !== 16'h5678 || ad_s !== 23'h2) begin
      failures++; $display("FAIL stall_second got aud=%h addr=%h exp aud=5678 addr=2", au_s, ad_s);
    end
  endtask

  task automatic test_dir_change;
    fetch_word(32'hCCCC_DDDD, rd_s, ad_s, au_s, vl_s);
    checks++;
    if (ad_s !== 23'h2 || au_s !== 16'hDDDD) begin
      failures++; $display("FAIL dirchg_first got addr=%h aud=%h exp addr=2 aud=DDDD", ad_s, au_s);
    end
    direction = 1'b1;
    tick_once(au_s, vl_s, ad_s);
    checks++;
    if (au_s !== 16'hCCCC || ad_s !== 23'h1) begin
      failures++; $display("FAIL dirchg_second got aud=%h addr=%h exp aud=CCCC addr=1", au_s, ad_s);
    end
    direction = 1'b0;
  endtask

  task automatic test_restart;
    logic [15:0] lo;
    for (int a = 1; a < 16; a++) begin
      lo = a[15:0];
      fetch_word({lo + 16'h0100, lo}, rd_s, ad_s, au_s, vl_s);
      checks++;
      if (ad_s !== a[22:0] || au_s !== lo) begin
        failures++; $display("FAIL walk_first[%0d] got addr=%h aud=%h exp addr=%h aud=%h", a, ad_s, au_s, a[22:0], lo);
      end
      tick_once(au_s, vl_s, ad_s);
      checks++;
      if (au_s !== lo + 16'h0100 || ad_s !== a[22:0] + 23'd1) begin
        failures++; $display("FAIL walk_second[%0d] got aud=%h addr=%h exp aud=%h addr=%h",
                             a, au_s, ad_s, lo + 16'h0100, a[22:0] + 23'd1);
      end
    end
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    checks++;
    if (flash_mem_read !== 1'b1 || flash_mem_address !== 23'h10) begin
      failures++; $display("FAIL rst_req got rd=%b addr=%h exp rd=1 addr=10", flash_mem_read, flash_mem_address);
    end
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    flash_mem_readdatavalid = 1'b1; flash_mem_readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    flash_mem_readdatavalid = 1'b0;
    checks++;
    if (sample_valid !== 1'b0 || audio_data !== 16'h010F || flash_mem_address !== 23'h0) begin
      failures++; $display("FAIL rst_discard got vld=%b aud=%h addr=%h exp vld=0 aud=010f addr=0",
                           sample_valid, audio_data, flash_mem_address);
    end
    fetch_word(32'h9999_8888, rd_s, ad_s, au_s, vl_s);
    checks++;
    if (rd_s !== 1'b1 || ad_s !== 23'h0 || au_s !== 16'h8888) begin
      failures++; $display("FAIL rst_refetch got rd=%b addr=%h aud=%h exp rd=1 addr=0 aud=8888", rd_s, ad_s, au_s);
    end
    @(negedge clk); direction = 1'b1; restart = 1'b1; sample_tick = 1'b1;
    @(negedge clk); restart = 1'b0; sample_tick = 1'b0;
    checks++;
    if (overrun !== 1'b0 || sample_valid !== 1'b0 || flash_mem_read !== 1'b0 || flash_mem_address !== 23'h7FFFF) begin
      failures++; $display("FAIL rst_tick got ovr=%b vld=%b rd=%b addr=%h exp ovr=0 vld=0 rd=0 addr=7ffff",
                           overrun, sample_valid, flash_mem_read, flash_mem_address);
    end
    fetch_word(32'h7777_6666, rd_s, ad_s, au_s, vl_s);
    checks++;
    if (rd_s !== 1'b1 || ad_s !== 23'h7FFFF || au_s !== 16'h7777) begin
      failures++; $display("FAIL rst_bwd_fetch got rd=%b addr=%h aud=%h exp rd=1 addr=7ffff aud=7777", rd_s, ad_s, au_s);
    end
    direction = 1'b0;
    tick_once(au_s, vl_s, ad_s);
    checks++;
    if (au_s !== 16'h6666 || ad_s !== 23'h0) begin
      failures++; $display("FAIL rst_bwd_second got aud=%h addr=%h exp aud=6666 addr=0", au_s, ad_s);
    end
  endtask

  task automatic test_pause_and_async_reset;
    int bad;
    play = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick_once(au_s, vl_s, ad_s);
      if (flash_mem_read !== 1'b0 || vl_s !== 1'b0 || overrun !== 1'b0 || au_s !== 16'h6666) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL pause_hold got bad=%0d aud=%h exp bad=0 aud=6666", bad, audio_data);
    end
    play = 1'b1;
    flash_mem_waitrequest = 1'b1;
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    checks++;
    if (flash_mem_read !== 1'b1) begin
      failures++; $display("FAIL async_pre got rd=%b exp rd=1", flash_mem_read);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (flash_mem_read !== 1'b0 || flash_mem_address !== 23'h0 || audio_data !== 16'h0 ||
        sample_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL async_reset got rd=%b addr=%h aud=%h vld=%b ovr=%b exp all zero",
                           flash_mem_read, flash_mem_address, audio_data, sample_valid, overrun);
    end
    @(negedge clk);
    reset_n = 1'b1; flash_mem_waitrequest = 1'b0;
    flash_mem_readdatavalid = 1'b1; flash_mem_readdata = 32'hFACE_CAFE;
    @(negedge clk);
    flash_mem_readdatavalid = 1'b0;
    @(negedge clk);
    checks++;
    if (sample_valid !== 1'b0 || audio_data !== 16'h0 || flash_mem_read !== 1'b0) begin
      failures++; $display("FAIL late_rdv got vld=%b aud=%h rd=%b exp vld=0 aud=0 rd=0",
                           sample_valid, audio_data, flash_mem_read);
    end
  endtask

  initial begin
    test_reset;
    test_forward;
    test_backward;
    test_end_wrap;
    test_stall;
    test_dir_change;
    test_restart;
    test_pause_and_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_sample_fetcher.md
Name: flash_sample_fetcher

Overview:
- Upstream feeder for the audio playback path: drives the flash Avalon-MM read master interface and splits each 32-bit flash word into two 16-bit PCM samples.
- Emits one sample per sample_tick.
- Control comes from the keyboard command controller as play, direction and restart levels/pulses.
- audio_data feeds the audio codec path directly.

Parameters:
- START_ADDR, 23'h000000, first word address of the sample region.
- END_ADDR, 23'h07FFFF, last word address of the sample region (inclusive).

Ports:
- CLK_50M  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- sample_tick  input  1  one-cycle pulse per 22 kHz period, already synchronised to CLK_50M.
- play  input  1  1 = advance on ticks; 0 = paused, audio_data held.
- direction  input  1  0 = forward, 1 = backward.
- restart  input  1  one-cycle pulse; rewinds to region start for the current direction.
- flash_mem_read  output  1  Avalon read request.
- flash_mem_address  output  23  Avalon word address.
- flash_mem_waitrequest  input  1  slave stall.
- flash_mem_readdatavalid  input  1  read data strobe.
- flash_mem_readdata  input  32  read data.
- audio_data  output  16  current sample (two's complement).
- sample_valid  output  1  one-cycle pulse when audio_data updates.
- overrun  output  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset values (async, reset_n=0):
  - flash_mem_read=0, flash_mem_address=START_ADDR, audio_data=0, sample_valid=0, overrun=0.
  - Internal: half=0, word buffer=0, restart_pending=0, state=IDLE.
- States: IDLE, REQ, WAIT_DATA.
- IDLE, on sample_tick with play=1:
  - half=0: enter REQ next cycle; flash_mem_read=1 at flash_mem_address.
  - half=1: next cycle audio_data = second half of the buffer, sample_valid=1, half<=0, address advances.
- IDLE, on sample_tick with play=0: ignored, no overrun.
- REQ:
  - flash_mem_read and address are held stable while flash_mem_waitrequest=1.
  - Acceptance = read & !waitrequest. On acceptance, flash_mem_read drops the next cycle and the state goes to WAIT_DATA.
- WAIT_DATA:
  - On flash_mem_readdatavalid, capture the word and the direction at capture time.
  - audio_data = first half, sample_valid=1, half<=1, state goes to IDLE, all on the next edge.
  - readdatavalid is ignored in IDLE/REQ.
- Half order:
  - Forward: [15:0] first, then [31:16].
  - Backward: [31:16] first, then [15:0].
- Address advance happens only after the second half is consumed:
  - Forward: address==END_ADDR ? START_ADDR : address+1.
  - Backward: address==START_ADDR ? END_ADDR : address-1.
- Latency: with waitrequest=0 and readdatavalid one cycle after acceptance, audio_data updates 3 cycles after the tick (fetch case) and 1 cycle after the tick (buffered case).
- sample_tick while in REQ/WAIT_DATA: dropped, overrun pulses 1 cycle, no queueing.
- restart:
  - In IDLE: address <= (direction ? END_ADDR : START_ADDR), half<=0, next cycle. No audio update.
  - In REQ/WAIT_DATA: restart_pending=1. The transaction completes per the Avalon rules, but captured data is discarded (no sample_valid, audio_data unchanged). The rewind is then applied on the return to IDLE.
  - Coincident with a tick in IDLE: restart wins, tick dropped, no overrun.
- direction change:
  - While half=1: the remaining buffered half is output in the order fixed at capture.
  - The new direction applies from the next address advance.
- play falling mid-transaction: the transaction completes and the sample is output; subsequent ticks are ignored.
- audio_data holds its value whenever sample_valid=0.
- reset_n asserted mid-transaction: flash_mem_read drops immediately (async); a late readdatavalid after reset is ignored.

Test Plan:
1. Reset, then play=1, direction=0, waitrequest=0, readdata=32'h0002_0001 -> read at 0. After tick 1: audio_data=16'h0001. After tick 2: audio_data=16'h0002. Address=1.
2. direction=1, address START_ADDR, word 32'hBBBB_AAAA -> audio_data 16'hBBBB then 16'hAAAA. Address wraps to 23'h07FFFF.
3. Forward at END_ADDR, both halves consumed -> address=0. Next tick issues read at 0.
4. waitrequest held 5 cycles, tick arriving during the stall -> flash_mem_read/address stable for 5 cycles. One overrun pulse, no sample_valid for that tick.
5. restart pulse during WAIT_DATA at address 23'h10 -> returned data discarded, audio_data unchanged, address=0. Next tick fetches 0.
6. play=0 with ticks -> no reads, audio_data holds. Mid-REQ reset_n=0 -> flash_mem_read=0 asynchronously, all outputs at reset values.
